// File: rtl/dual_port_bram.sv
// dual_port_bram: true dual-port synchronous RAM with registered read outputs.
// Port A wins same-address write collisions; cross-port reads see pre-write data.
module dual_port_bram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 65536,
    parameter int WRITE_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta,
    input  logic                  enb,
    input  logic                  web,
    input  logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] dinb,
    output logic [DATA_WIDTH-1:0] doutb
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic                  oka, okb;
    logic [IW-1:0]         ia, ib;
    logic [DATA_WIDTH-1:0] rda, rdb;

    assign oka = 32'(addra) < DEPTH;
    assign okb = 32'(addrb) < DEPTH;
    assign ia  = IW'(addra);
    assign ib  = IW'(addrb);
    assign rda = oka ? mem[ia] : '0;
    assign rdb = okb ? mem[ib] : '0;

    // A is applied last so its data survives a same-address dual write
    always_ff @(posedge clk) begin
        if (rst_n && enb && web && okb) mem[ib] <= dinb;
        if (rst_n && ena && wea && oka) mem[ia] <= dina;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            douta <= '0;
            doutb <= '0;
        end else begin
            if (ena) douta <= (wea && WRITE_MODE == 0 && oka) ? dina : rda;
            if (enb) doutb <= (web && WRITE_MODE == 0 && okb) ? dinb : rdb;
        end
    end
endmodule

// File: tb/tb_dual_port_bram.sv
// tb_dual_port_bram: write-first full-depth instance and read-first 1000-word
// instance driven in parallel, checked against an array model every cycle.
module tb_dual_port_bram;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena, wea, enb, web;
    logic [15:0] addra, dina, addrb, dinb;
    logic [15:0] douta0, doutb0, douta1, doutb1;

    int vecs = 0;
    int errs = 0;
    bit chk_on = 1'b0;

    logic [15:0] mm [2][65536];
    logic [15:0] ea [2];
    logic [15:0] eb [2];

    always #5 clk = ~clk;

    dual_port_bram #(.WRITE_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta0),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb0)
    );

    dual_port_bram #(.WRITE_MODE(1), .DEPTH(1000)) u1 (
        .clk(clk), .rst_n(rst_n),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta1),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb1)
    );

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Instance 0 is write-first over 65536 words, instance 1 read-first over 1000
    always @(posedge clk) begin
        logic [15:0] ra, rb;
        int d;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                d  = i ? 1000 : 65536;
                ra = (int'(addra) < d) ? mm[i][addra] : 16'h0;
                rb = (int'(addrb) < d) ? mm[i][addrb] : 16'h0;
                if (ena) ea[i] = (wea && i == 0 && int'(addra) < d) ? dina : ra;
                if (enb) eb[i] = (web && i == 0 && int'(addrb) < d) ? dinb : rb;
                if (enb && web && int'(addrb) < d) mm[i][addrb] = dinb;
                if (ena && wea && int'(addra) < d) mm[i][addra] = dina;
            end
        end
    end

    always @(negedge rst_n) begin
        ea[0] = '0; ea[1] = '0; eb[0] = '0; eb[1] = '0;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model u0.douta", douta0, ea[0]);
            chk("model u0.doutb", doutb0, eb[0]);
            chk("model u1.douta", douta1, ea[1]);
            chk("model u1.doutb", doutb1, eb[1]);
        end
    end

    task automatic cyc(input logic a_en, a_we, input logic [15:0] a_ad, a_d,
                       input logic b_en, b_we, input logic [15:0] b_ad, b_d);
        ena = a_en; wea = a_we; addra = a_ad; dina = a_d;
        enb = b_en; web = b_we; addrb = b_ad; dinb = b_d;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mm[0][i] = '0;
            mm[1][i] = '0;
        end
        ea[0] = '0; ea[1] = '0; eb[0] = '0; eb[1] = '0;
        rst_n = 1'b0;
        ena = 0; wea = 0; enb = 0; web = 0;
        addra = 0; dina = 0; addrb = 0; dinb = 0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);
        chk("reset douta", douta0, 16'h0000);
        chk("reset doutb", doutb1, 16'h0000);

        cyc(1, 1, 16'h0010, 16'hBEEF, 0, 0, 0, 0);
        chk("wf write douta", douta0, 16'hBEEF);
        chk("rf write douta", douta1, 16'h0000);
        cyc(0, 0, 0, 0, 1, 0, 16'h0010, 0);
        chk("B read 0x10 u0", doutb0, 16'hBEEF);
        chk("B read 0x10 u1", doutb1, 16'hBEEF);

        cyc(1, 1, 16'd3, 16'hAAAA, 0, 0, 0, 0);
        cyc(1, 1, 16'd3, 16'h5555, 0, 0, 0, 0);
        chk("write-first", douta0, 16'h5555);
        chk("read-first", douta1, 16'hAAAA);

        cyc(1, 1, 16'h0100, 16'h1111, 1, 1, 16'h0100, 16'h2222);
        chk("dual wr u0 doutb", doutb0, 16'h2222);
        chk("dual wr u1 doutb", doutb1, 16'h0000);
        cyc(0, 0, 0, 0, 1, 0, 16'h0100, 0);
        chk("dual wr A wins u0", doutb0, 16'h1111);
        chk("dual wr A wins u1", doutb1, 16'h1111);

        cyc(1, 1, 16'd5, 16'h0001, 0, 0, 0, 0);
        cyc(1, 1, 16'd5, 16'h7777, 1, 0, 16'd5, 0);
        chk("wr/rd collision old", doutb0, 16'h0001);
        cyc(0, 0, 0, 0, 1, 0, 16'd5, 0);
        chk("wr/rd collision new", doutb0, 16'h7777);

        cyc(1, 1, 16'd7, 16'h1234, 0, 0, 0, 0);
        chk("pre-reset douta", douta0, 16'h1234);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset douta", douta0, 16'h0000);
        chk("async reset doutb", doutb0, 16'h0000);
        chk("async reset u1 doutb", doutb1, 16'h0000);
        cyc(1, 1, 16'd7, 16'hDEAD, 1, 1, 16'd7, 16'hDEAD);
        chk("reset holds douta", douta0, 16'h0000);
        ena = 0; wea = 0; enb = 0; web = 0;
        rst_n = 1'b1;
        @(negedge clk);
        cyc(1, 0, 16'd7, 0, 0, 0, 0, 0);
        chk("mem kept over reset u0", douta0, 16'h1234);
        chk("mem kept over reset u1", douta1, 16'h1234);

        cyc(0, 1, 16'd7, 16'hFFFF, 0, 0, 0, 0);
        chk("disabled hold", douta0, 16'h1234);
        cyc(1, 0, 16'd3, 0, 0, 0, 0, 0);
        cyc(1, 0, 16'd7, 0, 0, 0, 0, 0);
        chk("disabled no write", douta0, 16'h1234);

        cyc(1, 1, 16'h0000, 16'h0A0A, 1, 1, 16'hFFFF, 16'hCAFE);
        cyc(1, 0, 16'h0000, 0, 0, 0, 0, 0);
        chk("b2b addr 0", douta0, 16'h0A0A);
        cyc(1, 0, 16'hFFFF, 0, 0, 0, 0, 0);
        chk("b2b addr FFFF", douta0, 16'hCAFE);
        chk("out of range read", douta1, 16'h0000);

        cyc(0, 0, 0, 0, 1, 1, 16'd999, 16'h9999);
        cyc(0, 0, 0, 0, 1, 1, 16'd1000, 16'h8888);
        cyc(1, 0, 16'd999, 0, 1, 0, 16'd1000, 0);
        chk("last word u1", douta1, 16'h9999);
        chk("oor write ignored u1", doutb1, 16'h0000);
        chk("addr 1000 u0", doutb0, 16'h8888);

        for (int i = 0; i < 300; i++) begin
            logic [15:0] aa, ab;
            aa = $urandom_range(0, 3) == 0 ? 16'(996 + $urandom_range(0, 7)) : 16'($urandom_range(0, 7));
            ab = $urandom_range(0, 3) == 0 ? 16'(996 + $urandom_range(0, 7)) : 16'($urandom_range(0, 7));
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), aa, 16'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ab, 16'($urandom));
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
